decoder_unpack_stage: RTL and testbench

DECODER_UNPACK_STAGE -- requirements
Module: decoder_unpack_stage

---
 rtl/decoder_unpack_stage_pkg.sv | 33 +++
 rtl/decoder_unpack_stage_if.sv | 33 +++
 rtl/decoder_unpack_stage_ctrl_field_slice.sv | 23 ++
 rtl/decoder_unpack_stage.sv | 72 +++++++
 tb/tb_decoder_unpack_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/decoder_unpack_stage_pkg.sv
// decoder_unpack_stage_pkg: control word width, field bit positions and skid FSM states
package decoder_unpack_stage_pkg;
  localparam int CTRL_W = 39;
  localparam int AF_MSB = 38, AF_LSB = 35;
  localparam int I_MSB = 34, I_LSB = 34;
  localparam int ALU_MUX_SEL_MSB = 33, ALU_MUX_SEL_LSB = 33;
  localparam int SHIFT_TYPE_MSB = 32, SHIFT_TYPE_LSB = 30;
  localparam int CAD_MSB = 29, CAD_LSB = 25;
  localparam int GP_WE_MSB = 24, GP_WE_LSB = 24;
  localparam int GP_MUX_SEL_MSB = 23, GP_MUX_SEL_LSB = 22;
  localparam int BF_MSB = 21, BF_LSB = 18;
  localparam int PC_MUX_SELECT_MSB = 17, PC_MUX_SELECT_LSB = 16;
  localparam int MEM_WREN_MSB = 15, MEM_WREN_LSB = 15;
  localparam int RS_MSB = 14, RS_LSB = 10;
  localparam int RT_MSB = 9, RT_LSB = 5;
  localparam int RD_MSB = 4, RD_LSB = 0;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [3:0] af;
    logic       i;
    logic       alu_mux_sel;
    logic [2:0] shift_type;
    logic [4:0] cad;
    logic       gp_we;
    logic [1:0] gp_mux_sel;
    logic [3:0] bf;
    logic [1:0] pc_mux_select;
    logic       mem_wren;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ctrl_fields_t;
endpackage

// File: rtl/decoder_unpack_stage_if.sv
// decoder_unpack_stage_if: packed-word input channel, flush and unpacked output channel
interface decoder_unpack_stage_if;
  import decoder_unpack_stage_pkg::*;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] packed_in;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        af;
  logic              i;
  logic              alu_mux_sel;
  logic [2:0]        shift_type;
  logic [4:0]        cad;
  logic              gp_we;
  logic [1:0]        gp_mux_sel;
  logic [3:0]        bf;
  logic [1:0]        pc_mux_select;
  logic              mem_wren;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  modport master (
    output flush, in_valid, packed_in, out_ready,
    input  in_ready, out_valid, af, i, alu_mux_sel, shift_type, cad, gp_we, gp_mux_sel,
           bf, pc_mux_select, mem_wren, rs, rt, rd
  );
  modport slave (
    input  flush, in_valid, packed_in, out_ready,
    output in_ready, out_valid, af, i, alu_mux_sel, shift_type, cad, gp_we, gp_mux_sel,
           bf, pc_mux_select, mem_wren, rs, rt, rd
  );
endinterface

// File: rtl/decoder_unpack_stage_ctrl_field_slice.sv
// ctrl_field_slice: combinational split of a packed control word into its named fields
module ctrl_field_slice
  import decoder_unpack_stage_pkg::*;
(
  input  logic [CTRL_W-1:0] word,
  output ctrl_fields_t      fields
);
  always_comb begin
    fields.af            = word[AF_MSB:AF_LSB];
    fields.i             = word[I_MSB];
    fields.alu_mux_sel   = word[ALU_MUX_SEL_MSB];
    fields.shift_type    = word[SHIFT_TYPE_MSB:SHIFT_TYPE_LSB];
    fields.cad           = word[CAD_MSB:CAD_LSB];
    fields.gp_we         = word[GP_WE_MSB];
    fields.gp_mux_sel    = word[GP_MUX_SEL_MSB:GP_MUX_SEL_LSB];
    fields.bf            = word[BF_MSB:BF_LSB];
    fields.pc_mux_select = word[PC_MUX_SELECT_MSB:PC_MUX_SELECT_LSB];
    fields.mem_wren      = word[MEM_WREN_MSB];
    fields.rs            = word[RS_MSB:RS_LSB];
    fields.rt            = word[RT_MSB:RT_LSB];
    fields.rd            = word[RD_MSB:RD_LSB];
  end
endmodule

// File: rtl/decoder_unpack_stage.sv
// decoder_unpack_stage: 2-entry skid buffer between decode and execute, unpacking the control word
module decoder_unpack_stage #(
  parameter int CTRL_W = decoder_unpack_stage_pkg::CTRL_W
) (
  input logic clk,
  input logic rst_n,
  decoder_unpack_stage_if.slave bus
);
  import decoder_unpack_stage_pkg::*;
  state_t            state, next_state;
  logic [CTRL_W-1:0] main_q, skid_q;
  logic              in_ready_q;
  logic              load_main, load_skid, main_from_skid;
  logic              out_valid, in_fire, out_fire;
  ctrl_fields_t      f;
  assign out_valid = state != EMPTY;
  assign in_fire   = bus.in_valid & in_ready_q & ~bus.flush;
  assign out_fire  = out_valid & bus.out_ready;
  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        load_main  = in_fire;
        next_state = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        load_main  = in_fire & out_fire;
        load_skid  = in_fire & ~out_fire;
        next_state = (in_fire & ~out_fire) ? TWO : (~in_fire & out_fire) ? EMPTY : ONE;
      end
      TWO: begin
        main_from_skid = out_fire;
        next_state     = out_fire ? ONE : TWO;
      end
      default: next_state = EMPTY;
    endcase
    if (bus.flush) next_state = EMPTY;
  end
  // in_ready is registered from the next state so it never sees out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= next_state;
      in_ready_q <= next_state != TWO;
      main_q     <= load_main ? bus.packed_in : main_from_skid ? skid_q : main_q;
      skid_q     <= load_skid ? bus.packed_in : skid_q;
    end
  end
  ctrl_field_slice u_slice (.word(main_q), .fields(f));
  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid;
  assign bus.af            = f.af;
  assign bus.i             = f.i;
  assign bus.alu_mux_sel   = f.alu_mux_sel;
  assign bus.shift_type    = f.shift_type;
  assign bus.cad           = f.cad;
  assign bus.gp_we         = f.gp_we & out_valid;
  assign bus.gp_mux_sel    = f.gp_mux_sel;
  assign bus.bf            = f.bf;
  assign bus.pc_mux_select = f.pc_mux_select;
  assign bus.mem_wren      = f.mem_wren & out_valid;
  assign bus.rs            = f.rs;
  assign bus.rt            = f.rt;
  assign bus.rd            = f.rd;
endmodule

// File: tb/tb_decoder_unpack_stage.sv
// tb_decoder_unpack_stage: randomized and directed checks against a queue-based model of the stage
module tb_decoder_unpack_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  decoder_unpack_stage_if bus();
  decoder_unpack_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [38:0] got;
  assign got = {bus.af, bus.i, bus.alu_mux_sel, bus.shift_type, bus.cad, bus.gp_we, bus.gp_mux_sel,
                bus.bf, bus.pc_mux_select, bus.mem_wren, bus.rs, bus.rt, bus.rd};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: the stage is a FIFO of capacity two whose ready flag lags occupancy by one edge
  logic [38:0] q[$];
  logic [38:0] out_log[$];
  bit rdy = 1'b0;
  bit m_in, m_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      rdy = 1'b0;
    end else begin
      m_in  = bus.in_valid && rdy && !bus.flush;
      m_out = q.size() != 0 && bus.out_ready;
      if (m_out) void'(q.pop_front());
      if (bus.flush) q.delete();
      else if (m_in) q.push_back(bus.packed_in);
      rdy = q.size() < 2;
    end
  end

  always @(negedge clk) begin
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (!rst_n) check("reset_fields", 64'(got), 64'd0);
    else if (q.size() != 0) check("fields", 64'(got), 64'(q[0]));
    else check("gated_we", {62'd0, bus.gp_we, bus.mem_wren}, 64'd0);
    if (rst_n && bus.out_valid && bus.out_ready) out_log.push_back(got);
  end

  task automatic wait_accept();
    bit acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [38:0] w);
    bus.in_valid  = 1'b1;
    bus.packed_in = w;
    wait_accept();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [38:0] rnd();
    return 39'({$urandom(), $urandom()});
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [38:0] w[3];
    logic [38:0] sent[$];
    logic [38:0] c;
    int base;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.packed_in = '0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // one word: af=A, rd=17, gp_we=1
    bus.out_ready = 1'b1;
    send({4'hA, 10'd0, 1'b1, 19'd0, 5'd17});
    check("first_valid", 64'(bus.out_valid), 64'd1);
    check("first_af", 64'(bus.af), 64'hA);
    check("first_rd", 64'(bus.rd), 64'd17);
    check("first_gp_we", 64'(bus.gp_we), 64'd1);
    step(2);

    // backpressure: W0, W1 fill the buffer, W2 waits at the input
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) w[k] = rnd();
    base = out_log.size();
    send(w[0]);
    send(w[1]);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.packed_in = w[2];
    step(3);
    check("held_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    wait_accept();
    step(4);
    check("bp_count", 64'(out_log.size()), 64'(base + 3));
    for (int k = 0; k < 3; k++)
      if (out_log.size() > base + k) check("bp_order", 64'(out_log[base + k]), 64'(w[k]));

    // flush while full, with a word offered in the same cycle
    bus.out_ready = 1'b0;
    send(rnd() | 39'h0001008000);
    send(rnd() | 39'h0001008000);
    base = out_log.size();
    c = rnd();
    bus.in_valid = 1'b1;
    bus.packed_in = c;
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_gp_we", 64'(bus.gp_we), 64'd0);
    check("flush_mem_wren", 64'(bus.mem_wren), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    step(3);
    check("flush_dropped", 64'(out_log.size()), 64'(base));

    // streaming: one word per cycle, output equals input delayed by one
    base = out_log.size();
    for (int k = 0; k < 100; k++) begin
      sent.push_back(rnd());
      bus.in_valid = 1'b1;
      bus.packed_in = sent[k];
      step(1);
    end
    bus.in_valid = 1'b0;
    step(3);
    check("stream_count", 64'(out_log.size()), 64'(base + 100));
    for (int k = 0; k < 100; k++)
      if (out_log.size() > base + k && out_log[base + k] !== sent[k])
        check("stream_order", 64'(out_log[base + k]), 64'(sent[k]));

    // random traffic with occasional flush
    for (int k = 0; k < 300; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.packed_in = rnd();
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.flush = $urandom_range(0, 15) == 0;
      step(1);
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    // walking one across the packed word
    for (int b = 0; b < 39; b++) begin
      send(39'd1 << b);
      check("walk_onehot", 64'($countones(got)), 64'd1);
      if (b == 38) check("walk_af", 64'(bus.af), 64'h8);
      if (b == 24) check("walk_gp_we", 64'(bus.gp_we), 64'd1);
      if (b == 15) check("walk_mem_wren", 64'(bus.mem_wren), 64'd1);
      if (b == 0) check("walk_rd", 64'(bus.rd), 64'd1);
    end
    step(2);

    // asynchronous reset mid-cycle while full
    bus.out_ready = 1'b0;
    send(rnd() | 39'h0001008000);
    send(rnd());
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_fields", 64'(got), 64'd0);
    check("async_in_ready", 64'(bus.in_ready), 64'd0);
    step(2);
    rst_n = 1'b1;
    check("rel_in_ready_low", 64'(bus.in_ready), 64'd0);
    step(1);
    check("rel_in_ready_high", 64'(bus.in_ready), 64'd1);
    check("rel_out_valid", 64'(bus.out_valid), 64'd0);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
